// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the LC-3b memory arbiter: default word/mask
// types, FSM state encoding and arbitration policy selectors.
package mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef logic [1:0] mem_arb_state_t;
  localparam mem_arb_state_t MEM_ARB_IDLE = 2'd0;
  localparam mem_arb_state_t MEM_ARB_BUSY = 2'd1;
  localparam mem_arb_state_t MEM_ARB_TURN = 2'd2;

  localparam int MEM_ARB_RR    = 0;
  localparam int MEM_ARB_FIXED = 1;

  // Index width that stays legal (>=1) for a single-port arbiter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// Combinational winner selection: round-robin starting after last_grant,
// or fixed priority where the lowest active index wins.
module arb_picker
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = MEM_ARB_RR,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] active,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    if (ARB_MODE == MEM_ARB_FIXED) begin
      // Descending scan so the lowest active index is the final assignment.
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
        if (active[j]) begin
          valid  = 1'b1;
          winner = IDX_W'(j);
        end
      end
    end else begin
      // Largest offset first, so offset 1 (the port after last_grant) wins ties.
      for (int off = NUM_PORTS; off >= 1; off--) begin
        for (int j = 0; j < NUM_PORTS; j++) begin
          if (active[j] && (((int'(last_grant) + off) % NUM_PORTS) == j)) begin
            valid  = 1'b1;
            winner = IDX_W'(j);
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port LC-3b memory arbiter: grants one requester at a time, registers its
// command onto the shared memory port and routes the response back to it.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ARB_MODE   = MEM_ARB_RR
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req_read,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_byte_enable,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]                req_resp,
  output logic [DATA_WIDTH-1:0]               req_rdata,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [DATA_WIDTH/8-1:0]             mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic                                mem_resp,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output mem_arb_state_t                      dbg_state
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_width(NUM_PORTS);

  // Requester handshake: a port holds read/write (with its address, data and
  // mask stable) until req_resp pulses for it; the pulse is one cycle wide and
  // coincides with mem_resp while that port's transaction is in flight.

  mem_arb_state_t   state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;

  logic [NUM_PORTS-1:0] active;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  logic                  sel_read;
  logic                  sel_write;
  logic [MASK_W-1:0]     sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign active = req_read | req_write;

  arb_picker #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE),
    .IDX_W     (IDX_W)
  ) u_picker (
    .active     (active),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_idx)
  );

  always_comb begin
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_read  = req_read[i];
        sel_write = req_write[i];
        sel_be    = req_byte_enable[i*MASK_W +: MASK_W];
        sel_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= MEM_ARB_IDLE;
      grant           <= '0;
      last_grant      <= IDX_W'(NUM_PORTS - 1);
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
    end else begin
      case (state)
        MEM_ARB_IDLE: begin
          if (pick_valid) begin
            // Read+write together is a write.
            mem_write       <= sel_write;
            mem_read        <= sel_read & ~sel_write;
            mem_byte_enable <= sel_be;
            mem_address     <= sel_addr;
            mem_wdata       <= sel_wdata;
            grant           <= pick_idx;
            last_grant      <= pick_idx;
            state           <= MEM_ARB_BUSY;
          end
        end
        MEM_ARB_BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= MEM_ARB_TURN;
          end
        end
        MEM_ARB_TURN: begin
          state <= MEM_ARB_IDLE;
        end
        default: begin
          state <= MEM_ARB_IDLE;
        end
      endcase
    end
  end

  // Response is routed only while a transaction is in flight.
  always_comb begin
    req_resp = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((state == MEM_ARB_BUSY) && mem_resp && (grant == IDX_W'(i))) begin
        req_resp[i] = 1'b1;
      end
    end
  end

  assign req_rdata = mem_rdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 4-port round-robin instance and a 4-port
// fixed-priority instance sharing requester inputs, each with its own mem_resp.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = DW / 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*MW-1:0] req_byte_enable;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_resp_a;
  logic            mem_resp_b;

  logic [N-1:0]   a_req_resp, b_req_resp;
  logic [DW-1:0]  a_req_rdata, b_req_rdata;
  logic           a_mem_read, b_mem_read;
  logic           a_mem_write, b_mem_write;
  logic [MW-1:0]  a_mem_be, b_mem_be;
  logic [AW-1:0]  a_mem_addr, b_mem_addr;
  logic [DW-1:0]  a_mem_wdata, b_mem_wdata;
  mem_arb_state_t a_state, b_state;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(MEM_ARB_RR)) u_dut_rr (
    .clk (clk), .rst_n (rst_n),
    .req_read (req_read), .req_write (req_write), .req_byte_enable (req_byte_enable),
    .req_address (req_address), .req_wdata (req_wdata),
    .req_resp (a_req_resp), .req_rdata (a_req_rdata),
    .mem_read (a_mem_read), .mem_write (a_mem_write), .mem_byte_enable (a_mem_be),
    .mem_address (a_mem_addr), .mem_wdata (a_mem_wdata),
    .mem_resp (mem_resp_a), .mem_rdata (mem_rdata), .dbg_state (a_state)
  );

  mem_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(MEM_ARB_FIXED)) u_dut_fix (
    .clk (clk), .rst_n (rst_n),
    .req_read (req_read), .req_write (req_write), .req_byte_enable (req_byte_enable),
    .req_address (req_address), .req_wdata (req_wdata),
    .req_resp (b_req_resp), .req_rdata (b_req_rdata),
    .mem_read (b_mem_read), .mem_write (b_mem_write), .mem_byte_enable (b_mem_be),
    .mem_address (b_mem_addr), .mem_wdata (b_mem_wdata),
    .mem_resp (mem_resp_b), .mem_rdata (mem_rdata), .dbg_state (b_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [MW-1:0] be);
    req_address[p*AW +: AW]     = addr;
    req_wdata[p*DW +: DW]       = wdata;
    req_byte_enable[p*MW +: MW] = be;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // Reset with every port requesting and a stray mem_resp.
    rst_n      = 1'b0;
    req_read   = '1;
    req_write  = '0;
    mem_resp_a = 1'b1;
    mem_resp_b = 1'b1;
    mem_rdata  = 16'h0000;
    for (int i = 0; i < N; i++) set_port(i, 16'h1000 + 16'(i) * 16'h0110, 16'h0000, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_read",  {31'd0, a_mem_read},  32'd0);
    check("rst_mem_write", {31'd0, a_mem_write}, 32'd0);
    check("rst_mem_addr",  {16'd0, a_mem_addr},  32'd0);
    check("rst_mem_be",    {30'd0, a_mem_be},    32'd0);
    check("rst_req_resp",  {28'd0, a_req_resp},  32'd0);
    check("rst_state",     {30'd0, a_state},     32'(MEM_ARB_IDLE));
    check("rst_fix_read",  {31'd0, b_mem_read},  32'd0);
    mem_rdata  = 16'h5A5A;
    #1;
    check("rst_rdata_pass", {16'd0, a_req_rdata}, 32'h5A5A);
    rst_n      = 1'b1;
    mem_resp_a = 1'b0;
    mem_resp_b = 1'b0;

    // Round-robin fairness with continuous requests.
    cyc();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr%0d_addr", k), {16'd0, a_mem_addr}, 32'h1000 + 32'(order[k]) * 32'h0110);
      check($sformatf("rr%0d_read", k), {31'd0, a_mem_read}, 32'd1);
      mem_resp_a = 1'b1;
      mem_rdata  = 16'hA000 + 16'(k);
      #1;
      check($sformatf("rr%0d_resp", k),  {28'd0, a_req_resp},  32'd1 << order[k]);
      check($sformatf("rr%0d_rdata", k), {16'd0, a_req_rdata}, 32'hA000 + 32'(k));
      cyc();
      check($sformatf("rr%0d_turn_state", k), {30'd0, a_state}, 32'(MEM_ARB_TURN));
      check($sformatf("rr%0d_turn_read", k),  {31'd0, a_mem_read}, 32'd0);
      check($sformatf("rr%0d_turn_resp", k),  {28'd0, a_req_resp}, 32'd0);
      cyc();
      check($sformatf("rr%0d_idle_state", k), {30'd0, a_state}, 32'(MEM_ARB_IDLE));
      check($sformatf("rr%0d_idle_resp", k),  {28'd0, a_req_resp}, 32'd0);
      mem_resp_a = 1'b0;
      if (k == 4) req_read = '0;
      cyc();
    end
    check("rr_drained_state", {30'd0, a_state}, 32'(MEM_ARB_IDLE));

    // Single read from port 1, two-cycle memory latency.
    set_port(1, 16'h1234, 16'h0000, 2'b11);
    req_read = 4'b0010;
    cyc();
    check("rd_read",  {31'd0, a_mem_read},  32'd1);
    check("rd_write", {31'd0, a_mem_write}, 32'd0);
    check("rd_addr",  {16'd0, a_mem_addr},  32'h1234);
    check("rd_wait_resp", {28'd0, a_req_resp}, 32'd0);
    cyc();
    mem_resp_a = 1'b1;
    mem_rdata  = 16'hBEEF;
    #1;
    check("rd_resp",  {28'd0, a_req_resp},  32'b0010);
    check("rd_rdata", {16'd0, a_req_rdata}, 32'hBEEF);
    req_read = '0;
    cyc();
    mem_resp_a = 1'b0;
    check("rd_after_read", {31'd0, a_mem_read}, 32'd0);
    cyc();

    // Masked write from port 0 with read also set; requester drops mid-BUSY.
    set_port(0, 16'h0040, 16'h00AA, 2'b01);
    req_read  = 4'b0001;
    req_write = 4'b0001;
    cyc();
    check("wr_write", {31'd0, a_mem_write}, 32'd1);
    check("wr_read",  {31'd0, a_mem_read},  32'd0);
    check("wr_wdata", {16'd0, a_mem_wdata}, 32'h00AA);
    check("wr_be",    {30'd0, a_mem_be},    32'b01);
    req_read  = '0;
    req_write = '0;
    set_port(0, 16'hFFFF, 16'hFFFF, 2'b11);
    cyc();
    check("wr_hold_write", {31'd0, a_mem_write}, 32'd1);
    check("wr_hold_wdata", {16'd0, a_mem_wdata}, 32'h00AA);
    check("wr_hold_be",    {30'd0, a_mem_be},    32'b01);
    check("wr_hold_addr",  {16'd0, a_mem_addr},  32'h0040);
    cyc();
    mem_resp_a = 1'b1;
    #1;
    check("wr_resp", {28'd0, a_req_resp}, 32'b0001);
    cyc();
    mem_resp_a = 1'b0;
    check("wr_after_write", {31'd0, a_mem_write}, 32'd0);
    cyc();

    // Reset asserted two cycles into a BUSY read.
    set_port(2, 16'h2222, 16'h0000, 2'b11);
    req_read = 4'b0100;
    cyc();
    check("ab_busy_read", {31'd0, a_mem_read}, 32'd1);
    check("ab_busy_addr", {16'd0, a_mem_addr}, 32'h2222);
    cyc();
    #2;
    rst_n      = 1'b0;
    mem_resp_a = 1'b1;
    #1;
    check("ab_async_read",  {31'd0, a_mem_read}, 32'd0);
    check("ab_async_addr",  {16'd0, a_mem_addr}, 32'd0);
    check("ab_no_resp",     {28'd0, a_req_resp}, 32'd0);
    check("ab_async_state", {30'd0, a_state},    32'(MEM_ARB_IDLE));
    req_read   = '0;
    mem_resp_a = 1'b0;
    rst_n      = 1'b1;
    cyc();
    check("ab_post_state", {30'd0, a_state},    32'(MEM_ARB_IDLE));
    check("ab_post_read",  {31'd0, a_mem_read}, 32'd0);

    // Fixed priority: ports 0 and 2 requesting; port 0 starves port 2.
    set_port(0, 16'h1000, 16'h0000, 2'b11);
    set_port(2, 16'h1220, 16'h0000, 2'b11);
    req_read = 4'b0101;
    cyc();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("fx%0d_addr", k), {16'd0, b_mem_addr}, 32'h1000);
      check($sformatf("fx%0d_read", k), {31'd0, b_mem_read}, 32'd1);
      mem_resp_b = 1'b1;
      #1;
      check($sformatf("fx%0d_resp", k), {28'd0, b_req_resp}, 32'b0001);
      cyc();
      mem_resp_b = 1'b0;
      cyc();
      if (k == 2) req_read = 4'b0100;
      cyc();
    end
    check("fx_p2_addr", {16'd0, b_mem_addr}, 32'h1220);
    check("fx_p2_read", {31'd0, b_mem_read}, 32'd1);
    mem_resp_b = 1'b1;
    #1;
    check("fx_p2_resp", {28'd0, b_req_resp}, 32'b0100);
    req_read = '0;
    cyc();
    mem_resp_b = 1'b0;
    check("fx_p2_turn", {30'd0, b_state}, 32'(MEM_ARB_TURN));

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
